// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration register bank.
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK
    } state_e;

    // Writing this pointer copies every shadow register to the live outputs.
    localparam logic [7:0] COMMIT_ADDR = 8'hFF;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Conditioned bus view: filtered SDA level plus single-cycle event pulses.
    typedef struct packed {
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } bus_evt_t;

endpackage

// File: rtl/i2c_bus_filter.sv
// Synchronises and deglitches SCL/SDA, then derives edge and START/STOP pulses.
module i2c_bus_filter
    import i2c_cfg_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     scl,
    input  logic     sda,
    output bus_evt_t evt
);

    localparam int CW = $clog2(FILT_LEN + 1);

    // Index 0 = SCL, index 1 = SDA.
    logic [1:0]         meta_q, meta_d;
    logic [1:0]         sync_q, sync_d;
    logic [1:0]         filt_q, filt_d;
    logic [1:0]         prev_q, prev_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    // Accept a new level only after FILT_LEN consecutive differing samples.
    always_comb begin
        meta_d = {sda, scl};
        sync_d = meta_q;
        prev_d = filt_q;
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
                filt_d[i] = sync_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Filter state; an idle bus has both lines high.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
            filt_q <= 2'b11;
            prev_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            filt_q <= filt_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    // START/STOP require SCL high both before and after the SDA transition.
    always_comb begin
        evt.sda      = filt_q[1];
        evt.scl_rise = filt_q[0] & ~prev_q[0];
        evt.scl_fall = ~filt_q[0] & prev_q[0];
        evt.start    = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
        evt.stop     = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];
    end

endmodule

// File: rtl/i2c_cfg_regbank.sv
// I2C slave register bank: R/W output regs (optionally shadowed) plus read-only inputs.
module i2c_cfg_regbank
    import i2c_cfg_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         NUM_OUT    = 12,
    parameter int         NUM_IN     = 4,
    parameter int         FILT_LEN   = 3,
    parameter bit         SHADOW     = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    scl,
    input  logic                                    sdaIn,
    output logic                                    sdaOut,
    output logic [NUM_OUT*8-1:0]                    outputs,
    input  logic [NUM_OUT*8-1:0]                    defaults,
    input  logic [(NUM_IN > 0 ? NUM_IN : 1)*8-1:0]  inputs,
    output logic [NUM_OUT-1:0]                      wr_strobe,
    output logic                                    commit_pulse
);

    bus_evt_t evt;

    i2c_bus_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sdaIn),
        .evt (evt)
    );

    state_e                   state_q, state_d;
    logic [2:0]               bit_q, bit_d;
    logic [7:0]               shift_q, shift_d;
    logic [7:0]               ptr_q, ptr_d;
    logic                     sda_out_q, sda_out_d;
    logic [NUM_OUT-1:0][7:0]  shadow_q, shadow_d;
    logic [NUM_OUT-1:0][7:0]  live_q, live_d;
    logic [NUM_OUT-1:0]       strobe_q, strobe_d;
    logic                     commit_q, commit_d;

    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic       load_rd;

    assign rx_byte = {shift_q[6:0], evt.sda};

    // Read source for the current pointer; unmapped addresses (incl. 0xFF) read 0.
    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (ptr_q == 8'(k)) rd_byte = shadow_q[k];
        end
        for (int j = 0; j < NUM_IN; j++) begin
            if (ptr_q == 8'(NUM_OUT + j)) rd_byte = inputs[8*j +: 8];
        end
    end

    // Protocol FSM: byte reception on SCL rise, all SDA driving on SCL fall.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_out_d = sda_out_q;
        shadow_d  = shadow_q;
        live_d    = live_q;
        strobe_d  = '0;
        commit_d  = 1'b0;
        load_rd   = 1'b0;

        if (evt.start) begin
            state_d   = ADDR;
            bit_d     = '0;
            sda_out_d = I2C_NACK;
        end else if (evt.stop) begin
            state_d   = IDLE;
            bit_d     = '0;
            sda_out_d = I2C_NACK;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (evt.scl_rise) begin
                        shift_d = rx_byte;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                // The R/W bit stays in shift_q[0] through ADDR_ACK.
                                state_d = (rx_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte;
                                state_d = PTR_ACK;
                            end else begin
                                state_d = WACK;
                                ptr_d   = ptr_q + 8'd1;
                                for (int k = 0; k < NUM_OUT; k++) begin
                                    if (ptr_q == 8'(k)) begin
                                        shadow_d[k] = rx_byte;
                                        strobe_d[k] = 1'b1;
                                        if (!SHADOW) live_d[k] = rx_byte;
                                    end
                                end
                                if (ptr_q == COMMIT_ADDR) begin
                                    live_d   = shadow_q;
                                    commit_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WACK: begin
                    // First fall opens the ACK bit, second fall closes it.
                    if (evt.scl_fall) begin
                        if (sda_out_q == I2C_NACK) begin
                            sda_out_d = I2C_ACK;
                        end else begin
                            sda_out_d = I2C_NACK;
                            bit_d     = '0;
                            if (state_q == ADDR_ACK && shift_q[0]) load_rd = 1'b1;
                            else if (state_q == ADDR_ACK)          state_d = PTR;
                            else                                    state_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (evt.scl_fall) begin
                        if (bit_q == 3'd7) begin
                            sda_out_d = I2C_NACK;
                            bit_d     = '0;
                            state_d   = RACK;
                        end else begin
                            shift_d   = {shift_q[6:0], shift_q[7]};
                            sda_out_d = shift_q[6];
                            bit_d     = bit_q + 3'd1;
                        end
                    end
                end
                RACK: begin
                    if (evt.scl_rise && evt.sda == I2C_NACK) state_d = IDLE;
                    else if (evt.scl_fall)                   load_rd = 1'b1;
                end
                default: ;
            endcase

            // Fetch the next read byte and present its MSB immediately.
            if (load_rd) begin
                shift_d   = rd_byte;
                sda_out_d = rd_byte[7];
                ptr_d     = ptr_q + 8'd1;
                bit_d     = '0;
                state_d   = RDATA;
            end
        end
    end

    // State registers; reset reloads both register copies from defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_out_q <= I2C_NACK;
            shadow_q  <= defaults;
            live_q    <= defaults;
            strobe_q  <= '0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_out_q <= sda_out_d;
            shadow_q  <= shadow_d;
            live_q    <= live_d;
            strobe_q  <= strobe_d;
            commit_q  <= commit_d;
        end
    end

    assign sdaOut       = sda_out_q;
    assign outputs      = live_q;
    assign wr_strobe    = strobe_q;
    assign commit_pulse = commit_q;

endmodule

// File: tb/tb_i2c_cfg_regbank.sv
// Directed bench: I2C master BFM on an open-drain bus, SCL = clk/20.
module tb_i2c_cfg_regbank;

    localparam int NO = 12;
    localparam int NI = 4;
    localparam int Q  = 50;   // quarter SCL period in ns

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            scl_m = 1'b1;
    logic            sda_m = 1'b1;
    logic            sda_o;
    logic            sda_line;
    logic [NO*8-1:0] outs;
    logic [NO*8-1:0] defs;
    logic [NO*8-1:0] exp_out;
    logic [NI*8-1:0] ins;
    logic [NO-1:0]   strb;
    logic            cmt;

    int tests = 0;
    int fails = 0;
    int strobe_cnt [NO];
    int commit_cnt = 0;

    assign sda_line = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_cfg_regbank #(
        .SLAVE_ADDR (7'h3C), .NUM_OUT (NO), .NUM_IN (NI), .FILT_LEN (3), .SHADOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scl          (scl_m),
        .sdaIn        (sda_line),
        .sdaOut       (sda_o),
        .outputs      (outs),
        .defaults     (defs),
        .inputs       (ins),
        .wr_strobe    (strb),
        .commit_pulse (cmt)
    );

    // Count high cycles of each pulse output.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NO; k++) strobe_cnt[k] <= strobe_cnt[k] + int'(strb[k]);
            commit_cnt <= commit_cnt + int'(cmt);
        end
    end

    function automatic int strobe_total();
        int s = 0;
        for (int k = 0; k < NO; k++) s += strobe_cnt[k];
        return s;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        chk(nm, 96'(act), 96'(exp));
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 96'(act), 96'(exp));
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        chk(nm, 96'(act), 96'(exp));
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(2*Q);
    endtask

    // Optional glitches: 1-clk SCL high pulse in bit 2's low phase, 1-clk low pulse in bit 4's high phase.
    task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];
            if (glitch && i == 2) begin
                #20; scl_m = 1'b1; #10; scl_m = 1'b0; #20;
            end else begin
                #Q;
            end
            scl_m = 1'b1;
            if (glitch && i == 4) begin
                #40; scl_m = 1'b0; #10; scl_m = 1'b1; #50;
            end else begin
                #(2*Q);
            end
            scl_m = 1'b0; #Q;
        end
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        ack = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; #Q;
            scl_m = 1'b1; #Q;
            b[i] = sda_line; #Q;
            scl_m = 1'b0; #Q;
        end
        bit_out(nack);
    endtask

    task automatic wr(input logic [7:0] p, input logic [31:0] dat, input int n);
        logic a;
        i2c_start;
        send_byte(8'h78, 1'b0, a); chk1("wr addr ack", a, 1'b0);
        send_byte(p, 1'b0, a);     chk1("wr ptr ack", a, 1'b0);
        for (int i = 0; i < n; i++) begin
            send_byte(dat[8*i +: 8], 1'b0, a);
            chk1("wr data ack", a, 1'b0);
        end
        i2c_stop;
    endtask

    // Pointer write, repeated START, n-byte read (last byte NACKed).
    task automatic rd(input logic [7:0] p, input int n, output logic [31:0] dat);
        logic a;
        logic [7:0] b;
        dat = '0;
        i2c_start;
        send_byte(8'h78, 1'b0, a); chk1("rd addr ack", a, 1'b0);
        send_byte(p, 1'b0, a);     chk1("rd ptr ack", a, 1'b0);
        i2c_start;
        send_byte(8'h79, 1'b0, a); chk1("rd raddr ack", a, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            dat[8*i +: 8] = b;
        end
        i2c_stop;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] ptr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic        a;
        logic [7:0]  b;
        logic [31:0] d;
        int          s0, s1, c0;

        // reg k defaults to 46 + k
        for (int k = 0; k < NO; k++) defs[8*k +: 8] = 8'(46 + k);
        ins = 32'hDEADBEEF;

        tbl[0] = '{1'b0, 8'd0,   8'h00, 8'h2E};
        tbl[1] = '{1'b0, 8'd11,  8'h00, 8'h39};
        tbl[2] = '{1'b0, 8'd12,  8'h00, 8'hEF};
        tbl[3] = '{1'b0, 8'd15,  8'h00, 8'hDE};
        tbl[4] = '{1'b0, 8'd16,  8'h00, 8'h00};
        tbl[5] = '{1'b0, 8'hFF,  8'h00, 8'h00};
        tbl[6] = '{1'b1, 8'd2,   8'h5A, 8'h5A};
        tbl[7] = '{1'b1, 8'd13,  8'h99, 8'hBE};

        // 1: reset values, read reg 0, NACK ends the read
        #100;
        chk("rst outputs", outs, defs);
        chk1("rst sdaOut", sda_o, 1'b1);
        chk("rst wr_strobe", 96'(strb), 96'(0));
        chk1("rst commit", cmt, 1'b0);
        rst = 1'b0;
        #200;
        chk8("out0 after rst", outs[7:0], 8'd46);
        chkn("no strobes after rst", strobe_total(), 0);
        exp_out = defs;

        i2c_start;
        send_byte(8'h78, 1'b0, a); chk1("t1 addr ack", a, 1'b0);
        send_byte(8'h00, 1'b0, a); chk1("t1 ptr ack", a, 1'b0);
        i2c_start;
        send_byte(8'h79, 1'b0, a); chk1("t1 raddr ack", a, 1'b0);
        recv_byte(1'b1, b);        chk8("t1 read reg0", b, 8'h2E);
        chk1("t1 sda released", sda_o, 1'b1);
        recv_byte(1'b1, b);        chk8("t1 idle after nack", b, 8'hFF);
        i2c_stop;

        // 2: shadowed write, then commit
        s0 = strobe_cnt[3];
        wr(8'd3, 32'h15, 1);
        chkn("t2 strobe3", strobe_cnt[3] - s0, 1);
        chkn("t2 strobe total", strobe_total(), 1);
        chk8("t2 live3 held", outs[31:24], 8'h31);
        rd(8'd3, 1, d);
        chk8("t2 read shadow3", d[7:0], 8'h15);
        c0 = commit_cnt;
        wr(8'hFF, 32'h00, 1);
        chkn("t2 commit", commit_cnt - c0, 1);
        exp_out[31:24] = 8'h15;
        chk("t2 outputs after commit", outs, exp_out);

        // 3: burst past the last output reg, burst read of inputs
        s0 = strobe_total();
        wr(8'd10, 32'hA4A3A2A1, 4);
        chkn("t3 strobes", strobe_total() - s0, 2);
        chk("t3 outputs before commit", outs, exp_out);
        wr(8'hFF, 32'h00, 1);
        exp_out[95:80] = 16'hA2A1;
        chk("t3 outputs after commit", outs, exp_out);
        rd(8'd12, 4, d);
        chk("t3 burst read inputs", 96'(d), 96'(32'hDEADBEEF));

        // ptr wraps 0xFF -> 0x00: commit, then reg 0 written to shadow only
        s0 = strobe_cnt[0];
        c0 = commit_cnt;
        wr(8'hFF, 32'h7700, 2);
        chkn("wrap commit", commit_cnt - c0, 1);
        chkn("wrap strobe0", strobe_cnt[0] - s0, 1);
        chk8("wrap live0 held", outs[7:0], 8'd46);
        rd(8'd0, 1, d);
        chk8("wrap read shadow0", d[7:0], 8'h77);

        // 4: wrong addresses are not ACKed
        s0 = strobe_total();
        i2c_start; send_byte(8'h7A, 1'b0, a); chk1("addr 3D nack", a, 1'b1); i2c_stop;
        i2c_start; send_byte(8'h7C, 1'b0, a); chk1("addr 3E nack", a, 1'b1); i2c_stop;
        chk("t4 outputs untouched", outs, exp_out);
        chkn("t4 no strobes", strobe_total() - s0, 0);

        // START mid data byte: partial byte dropped, ptr kept
        i2c_start;
        send_byte(8'h78, 1'b0, a); chk1("t4 addr ack", a, 1'b0);
        send_byte(8'h05, 1'b0, a); chk1("t4 ptr ack", a, 1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b0);
        i2c_start;
        send_byte(8'h79, 1'b0, a); chk1("t4 restart ack", a, 1'b0);
        recv_byte(1'b1, b);        chk8("t4 reg5 unchanged", b, 8'h33);
        i2c_stop;
        chkn("t4 partial no strobe", strobe_total() - s0, 0);

        // 5: SCL glitches during a data byte
        s0 = strobe_cnt[6];
        s1 = strobe_total();
        i2c_start;
        send_byte(8'h78, 1'b0, a); chk1("t5 addr ack", a, 1'b0);
        send_byte(8'h06, 1'b0, a); chk1("t5 ptr ack", a, 1'b0);
        send_byte(8'hA5, 1'b1, a); chk1("t5 glitch data ack", a, 1'b0);
        i2c_stop;
        chkn("t5 strobe6", strobe_cnt[6] - s0, 1);
        chkn("t5 single strobe", strobe_total() - s1, 1);
        rd(8'd6, 1, d);
        chk8("t5 glitch read", d[7:0], 8'hA5);

        // rst during the address ACK low period
        i2c_start;
        for (int i = 7; i >= 0; i--) bit_out(1'(8'h78 >> i));
        sda_m = 1'b1;
        #40;
        chk1("t5 ack driven", sda_line, 1'b0);
        rst = 1'b1;
        #10;
        chk1("t5 rst releases sda", sda_o, 1'b1);
        chk("t5 rst outputs", outs, defs);
        #20;
        rst = 1'b0;
        #100;
        i2c_stop;
        rd(8'd3, 1, d);
        chk8("t5 shadow3 reset", d[7:0], 8'h31);

        // Table: optional write then single-byte read-back
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) wr(tbl[i].ptr, 32'(tbl[i].dat), 1);
            rd(tbl[i].ptr, 1, d);
            chk8($sformatf("tbl%0d ptr %0d", i, tbl[i].ptr), d[7:0], tbl[i].exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
